muestra_captura: RTL and testbench
==================================

Name: muestra_captura

Overview:
Sample-side consumer of the 48 kHz sample clock clk_lento produced by the sample-rate divider. Runs in the clk_medio domain and detects each rising edge of clk_lento. On each edge it captures one audio sample from the ADC/input bus into a holding register and offers it to the FIR core over a valid/ready handshake. It also watches the clk_lento period, reports lost or irregular sample clocks, and flags dropped samples (overrun).

Parameters:
DATA_W, 16, sample width in bits
PERIODO, 8, nominal clk_medio cycles per clk_lento period
TOL, 1, allowed deviation of the measured period, in clk_medio cycles
CNT_W, 16, width of the accepted-sample counter

Ports:
clk_medio  in  1  system clock (same domain as clk_lento generation)
reset  in  1  synchronous, active-high reset
clk_lento  in  1  48 kHz sample clock, registered in the clk_medio domain
din  in  DATA_W  incoming audio sample, stable around clk_lento rising edge
dout  out  DATA_W  captured sample to FIR
dout_valid  out  1  dout holds an unconsumed sample
dout_ready  in  1  FIR accepts dout this cycle
overrun  out  1  sticky: a sample was dropped
clk_fallo  out  1  sticky: sample clock missing or out of tolerance
n_muestras  out  CNT_W  count of samples loaded into dout, wraps modulo 2^CNT_W

Behaviour:
- All state updates on posedge clk_medio. reset is sampled synchronously and overrides everything else.
- Reset values: dout=0, dout_valid=0, overrun=0, clk_fallo=0, n_muestras=0, lento_q=1, cnt=0, state=INICIO.
- lento_q=1 at reset matches the divider's clk_lento=1 after reset, so no spurious edge is seen.
- Edge detection: edge = clk_lento & ~lento_q, with lento_q = clk_lento delayed one cycle. No synchroniser is needed because clk_lento is in the same domain.
- Capture on cycle t with edge=1:
  - if dout_valid=0 or dout_ready=1: dout<=din, dout_valid<=1, n_muestras+=1. Latency is 1 cycle (valid in t+1).
  - if dout_valid=1 and dout_ready=0: sample is dropped, dout is unchanged, overrun<=1.
- Cycle with no edge: dout_valid=1 and dout_ready=1 gives dout_valid<=0.
- Edge and handshake in the same cycle: the new sample is loaded, dout_valid stays 1, and the old sample counts as consumed.
- dout is stable while dout_valid=1 and dout_ready=0.
- Period counter cnt (width clog2(2*PERIODO+1)):
  - cleared on edge, otherwise incremented, saturating at 2*PERIODO.
  - Measured interval at an edge = cnt+1.
- FSM, states INICIO, ENGANCHADO, FALLO:
  - INICIO: an edge goes to ENGANCHADO (no interval check on the first edge). cnt reaching 2*PERIODO with no edge goes to FALLO.
  - ENGANCHADO: at an edge, an interval outside [PERIODO-TOL, PERIODO+TOL] goes to FALLO. cnt reaching PERIODO+TOL with no edge also goes to FALLO (timeout).
  - FALLO: sets clk_fallo<=1 on entry. The next edge goes to INICIO (re-lock).
- Capture and handshake run in every state; the FSM affects only the flags.
- overrun and clk_fallo are sticky and are cleared only by reset.
- Reset mid-operation: any pending sample is discarded (dout_valid=0) and the FSM returns to INICIO.
- n_muestras wraps from 2^CNT_W-1 to 0 without flagging.

Decomposition:
- Shared package: FSM state encoding (INICIO=2'd0, ENGANCHADO=2'd1, FALLO=2'd2), default PERIODO=8, DATA_W=16, and the function for the cnt width.
- One natural sub-module, flanco_subida: holds lento_q and outputs the one-cycle edge pulse. Its reset value for lento_q is a parameter, set to 1 here.

Test Plan:
- Nominal: clk_lento period 8 cycles, dout_ready=1, din = 0x0001, 0x0002, ... -> dout_valid pulses 1 cycle after each edge with the matching din; after 10 edges n_muestras=10, clk_fallo=0, overrun=0.
- Backpressure: dout_ready=0 across two edges with din=0x1234 then 0x5678 -> dout holds 0x1234, overrun=1 from the cycle after the second edge, n_muestras=1.
- Simultaneous: dout_valid=1 with dout_ready=1 on an edge cycle, din=0xABCD -> the next cycle has dout=0xABCD, dout_valid=1, overrun=0.
- Lost clock: hold clk_lento after lock -> clk_fallo=1 once cnt reaches PERIODO+TOL=9 with no edge; resuming edges re-locks via INICIO, and clk_fallo stays 1.
- Irregular period: one interval of 5 cycles (PERIODO=8, TOL=1) -> FALLO, clk_fallo=1; the sample captured on that edge is still delivered.
- Reset mid-stream: assert reset for 1 cycle while dout_valid=1 -> the next cycle shows all outputs at reset values, no spurious capture while clk_lento=1, and capture resumes on the next rising edge.

Source files
------------

// File: rtl/muestra_captura_pkg.sv
// Shared definitions for the sample-capture block: supervisor FSM encoding,
// default sizes and the period-counter width helper.
package muestra_captura_pkg;

  typedef enum logic [1:0] {
    INICIO     = 2'd0,
    ENGANCHADO = 2'd1,
    FALLO      = 2'd2
  } estado_t;

  localparam int DATA_W_DEF  = 16;
  localparam int PERIODO_DEF = 8;

  // The period counter must hold values 0 .. 2*periodo.
  function automatic int cnt_ancho(input int periodo);
    return $clog2(2 * periodo + 1);
  endfunction

endpackage

// File: rtl/muestra_captura_if.sv
// Valid/ready sample channel from the capture stage (master) to the FIR core (slave).
interface muestra_captura_if #(
  parameter int DATA_W = muestra_captura_pkg::DATA_W_DEF
) ();

  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );

endinterface

// File: rtl/muestra_captura_flanco_subida.sv
// Rising-edge detector for a signal already in the clk_medio domain; the
// delayed copy resets to RESET_VAL so a signal that idles high gives no edge.
module flanco_subida #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_medio,
  input  logic reset,
  input  logic entrada,
  output logic flanco
);

  logic lento_q;

  // NOTE: non-blocking so lento_q holds the previous cycle's value when the edge is formed.
  always_ff @(posedge clk_medio) begin
    if (reset) lento_q <= RESET_VAL;
    else       lento_q <= entrada;
  end

  assign flanco = entrada & ~lento_q;

endmodule

// File: rtl/muestra_captura.sv
// Captures one sample per clk_lento rising edge, offers it over valid/ready,
// and supervises the clk_lento period (lock / timeout / out-of-tolerance).
module muestra_captura
  import muestra_captura_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PERIODO = PERIODO_DEF,
  parameter int TOL     = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk_medio,
  input  logic               reset,
  input  logic               clk_lento,
  input  logic [DATA_W-1:0]  din,
  muestra_captura_if.master  salida,
  output logic               overrun,
  output logic               clk_fallo,
  output logic [CNT_W-1:0]   n_muestras
);

  localparam int CW = cnt_ancho(PERIODO);

  localparam logic [CW-1:0] CNT_SAT  = CW'(2 * PERIODO);
  localparam logic [CW-1:0] CNT_TOUT = CW'(PERIODO + TOL);
  localparam logic [CW:0]   INT_MIN  = (CW+1)'(PERIODO - TOL);
  localparam logic [CW:0]   INT_MAX  = (CW+1)'(PERIODO + TOL);

  logic          flanco;
  logic [CW-1:0] cnt;
  logic [CW:0]   intervalo;
  estado_t       estado;

  flanco_subida #(
    .RESET_VAL (1'b1)
  ) u_flanco (
    .clk_medio (clk_medio),
    .reset     (reset),
    .entrada   (clk_lento),
    .flanco    (flanco)
  );

  // Cycles from the previous edge up to and including this one.
  assign intervalo = {1'b0, cnt} + (CW+1)'(1);

  // Capture and handshake: a new edge overwrites only a slot that is empty
  // or being consumed this cycle; otherwise the incoming sample is dropped.
  always_ff @(posedge clk_medio) begin
    if (reset) begin
      salida.dout       <= '0;
      salida.dout_valid <= 1'b0;
      overrun           <= 1'b0;
      n_muestras        <= '0;
    end else if (flanco) begin
      if (!salida.dout_valid || salida.dout_ready) begin
        salida.dout       <= din;
        salida.dout_valid <= 1'b1;
        n_muestras        <= n_muestras + CNT_W'(1);
      end else begin
        overrun <= 1'b1;
      end
    end else if (salida.dout_valid && salida.dout_ready) begin
      salida.dout_valid <= 1'b0;
    end
  end

  // Period supervision; only the sticky clk_fallo flag depends on it.
  always_ff @(posedge clk_medio) begin
    if (reset) begin
      cnt       <= '0;
      estado    <= INICIO;
      clk_fallo <= 1'b0;
    end else begin
      if (flanco)              cnt <= '0;
      else if (cnt != CNT_SAT) cnt <= cnt + CW'(1);

      case (estado)
        INICIO: begin
          if (flanco) begin
            estado <= ENGANCHADO;
          end else if (cnt == CNT_SAT) begin
            estado    <= FALLO;
            clk_fallo <= 1'b1;
          end
        end
        ENGANCHADO: begin
          if (flanco) begin
            if (intervalo < INT_MIN || intervalo > INT_MAX) begin
              estado    <= FALLO;
              clk_fallo <= 1'b1;
            end
          end else if (cnt >= CNT_TOUT) begin
            estado    <= FALLO;
            clk_fallo <= 1'b1;
          end
        end
        FALLO: begin
          if (flanco) estado <= INICIO;
        end
        default: estado <= INICIO;
      endcase
    end
  end

endmodule

// File: tb/tb_muestra_captura.sv
// Bench for muestra_captura: directed scenarios plus randomized clk_lento
// periods and backpressure, all compared against a behavioural model.
module tb_muestra_captura;

  localparam int DATA_W  = 16;
  localparam int PERIODO = 8;
  localparam int TOL     = 1;
  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam int VW      = DATA_W + 3 + CNT_W;

  logic              clk_medio = 1'b0;
  logic              reset     = 1'b1;
  logic              clk_lento = 1'b1;
  logic [DATA_W-1:0] din       = '0;
  logic              overrun;
  logic              clk_fallo;
  logic [CNT_W-1:0]  n_muestras;

  muestra_captura_if #(.DATA_W(DATA_W)) bus ();

  muestra_captura #(
    .DATA_W  (DATA_W),
    .PERIODO (PERIODO),
    .TOL     (TOL),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_medio  (clk_medio),
    .reset      (reset),
    .clk_lento  (clk_lento),
    .din        (din),
    .salida     (bus),
    .overrun    (overrun),
    .clk_fallo  (clk_fallo),
    .n_muestras (n_muestras)
  );

  always #5 clk_medio = ~clk_medio;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: sample slot, sticky flags, and a clock supervisor
  // expressed as "cycles since the last edge" plus lock/lost status.
  logic [DATA_W-1:0] m_dout;
  bit                m_valid, m_overrun, m_fallo;
  int                m_count;
  bit                m_prev;
  int                m_elapsed;
  bit                m_locked, m_lost;

  logic [VW-1:0] dut_v;
  assign dut_v = {bus.dout, bus.dout_valid, overrun, clk_fallo, n_muestras};

  function automatic logic [VW-1:0] mdl_v();
    return {m_dout, m_valid, m_overrun, m_fallo, CNT_W'(m_count)};
  endfunction

  function automatic string fmt(input logic [VW-1:0] v);
    return $sformatf("dout=%h v=%b ovr=%b fallo=%b n=%0d",
                     v[VW-1 -: DATA_W], v[CNT_W+2], v[CNT_W+1], v[CNT_W], v[CNT_W-1:0]);
  endfunction

  task automatic model_step(input bit rst, input bit lento,
                            input logic [DATA_W-1:0] d, input bit rdy);
    bit edge_now;
    int limit;
    if (rst) begin
      m_dout = '0; m_valid = 0; m_overrun = 0; m_fallo = 0; m_count = 0;
      m_prev = 1; m_elapsed = 0; m_locked = 0; m_lost = 0;
      return;
    end
    edge_now  = lento && !m_prev;
    m_prev    = lento;
    m_elapsed = m_elapsed + 1;

    if (edge_now) begin
      if (!m_valid || rdy) begin
        m_dout  = d;
        m_valid = 1;
        m_count = (m_count + 1) % CNT_MOD;
      end else begin
        m_overrun = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end

    if (edge_now) begin
      if (m_lost) begin
        m_lost   = 0;
        m_locked = 0;
      end else if (!m_locked) begin
        m_locked = 1;
      end else if (m_elapsed < PERIODO - TOL || m_elapsed > PERIODO + TOL) begin
        m_lost  = 1;
        m_fallo = 1;
      end
      m_elapsed = 0;
    end else if (!m_lost) begin
      limit = m_locked ? PERIODO + TOL : 2 * PERIODO;
      if (m_elapsed > limit) begin
        m_lost  = 1;
        m_fallo = 1;
      end
    end
  endtask

  // Drive one cycle's inputs, advance the model, and land on the next negedge.
  task automatic tick(input bit rst, input bit lento,
                      input logic [DATA_W-1:0] d, input bit rdy);
    reset          = rst;
    clk_lento      = lento;
    din            = d;
    bus.dout_ready = rdy;
    model_step(rst, lento, d, rdy);
    @(posedge clk_medio);
    @(negedge clk_medio);
  endtask

  task automatic test_reset();
    tick(1, 1, 16'hFFFF, 0);
    tick(1, 1, 16'hFFFF, 0);
    n_checks++;
    if (dut_v !== '0) $display("FAIL reset_values: got %s want all zero", fmt(dut_v));
    else n_pass++;
    tick(0, 1, 16'h5555, 1);
    n_checks++;
    if (dut_v !== mdl_v()) $display("FAIL reset_no_edge: got %s want %s", fmt(dut_v), fmt(mdl_v()));
    else n_pass++;
  endtask

  task automatic test_nominal();
    tick(1, 1, 0, 1);
    for (int e = 1; e <= 10; e++) begin
      for (int c = 0; c < 8; c++) begin
        tick(0, c >= 4, DATA_W'(e), 1);
        n_checks++;
        if (dut_v !== mdl_v())
          $display("FAIL nominal e%0d c%0d: got %s want %s", e, c, fmt(dut_v), fmt(mdl_v()));
        else n_pass++;
        if (c == 4) begin
          n_checks++;
          if (bus.dout_valid !== 1'b1 || bus.dout !== DATA_W'(e))
            $display("FAIL nominal_capture e%0d: got %s want dout=%h v=1", e, fmt(dut_v), DATA_W'(e));
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (n_muestras !== CNT_W'(10) || clk_fallo !== 1'b0 || overrun !== 1'b0)
      $display("FAIL nominal_end: got %s want n=10 fallo=0 ovr=0", fmt(dut_v));
    else n_pass++;
  endtask

  task automatic test_backpressure();
    tick(1, 1, 0, 0);
    for (int c = 0; c < 8; c++) begin
      tick(0, c >= 4, 16'h1234, 0);
      n_checks++;
      if (dut_v !== mdl_v())
        $display("FAIL backpressure p1 c%0d: got %s want %s", c, fmt(dut_v), fmt(mdl_v()));
      else n_pass++;
    end
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL backpressure_no_early_ovr: got ovr=%b want 0", overrun);
    else n_pass++;
    for (int c = 0; c < 8; c++) begin
      tick(0, c >= 4, 16'h5678, 0);
      n_checks++;
      if (dut_v !== mdl_v())
        $display("FAIL backpressure p2 c%0d: got %s want %s", c, fmt(dut_v), fmt(mdl_v()));
      else n_pass++;
      if (c == 4) begin
        n_checks++;
        if (bus.dout !== 16'h1234 || bus.dout_valid !== 1'b1 || overrun !== 1'b1 || n_muestras !== CNT_W'(1))
          $display("FAIL backpressure_hold: got %s want dout=1234 v=1 ovr=1 n=1", fmt(dut_v));
        else n_pass++;
      end
    end
  endtask

  task automatic test_simultaneous();
    tick(1, 1, 0, 0);
    for (int c = 0; c < 8; c++) tick(0, c >= 4, 16'h1111, 0);
    for (int c = 0; c < 5; c++) tick(0, c >= 4, (c == 4) ? 16'hABCD : 16'h0000, c == 4);
    n_checks++;
    if (bus.dout !== 16'hABCD || bus.dout_valid !== 1'b1 || overrun !== 1'b0 || n_muestras !== CNT_W'(2))
      $display("FAIL simultaneous: got %s want dout=abcd v=1 ovr=0 n=2", fmt(dut_v));
    else n_pass++;
    n_checks++;
    if (dut_v !== mdl_v()) $display("FAIL simultaneous_model: got %s want %s", fmt(dut_v), fmt(mdl_v()));
    else n_pass++;
  endtask

  task automatic test_lost_clock();
    tick(1, 1, 0, 1);
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 8; c++) tick(0, c >= 4, DATA_W'($urandom), 1);
    for (int c = 0; c < 5; c++) tick(0, c >= 4, 16'h00AA, 1);
    for (int k = 1; k <= 12; k++) begin
      tick(0, 1, 16'h00BB, 1);
      n_checks++;
      if (dut_v !== mdl_v())
        $display("FAIL lost_clock k%0d: got %s want %s", k, fmt(dut_v), fmt(mdl_v()));
      else n_pass++;
      if (k == 9 || k == 10) begin
        n_checks++;
        if (clk_fallo !== (k == 10))
          $display("FAIL lost_clock_timeout k%0d: got fallo=%b want %b", k, clk_fallo, k == 10);
        else n_pass++;
      end
    end
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 8; c++) begin
        tick(0, c >= 4, DATA_W'(16'hC000 + p), 1);
        n_checks++;
        if (dut_v !== mdl_v())
          $display("FAIL relock p%0d c%0d: got %s want %s", p, c, fmt(dut_v), fmt(mdl_v()));
        else n_pass++;
      end
    n_checks++;
    if (clk_fallo !== 1'b1) $display("FAIL relock_sticky: got fallo=%b want 1", clk_fallo);
    else n_pass++;
  endtask

  task automatic test_irregular();
    tick(1, 1, 0, 1);
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 8; c++) tick(0, c >= 4, 16'h0101, 1);
    n_checks++;
    if (clk_fallo !== 1'b0) $display("FAIL irregular_pre: got fallo=%b want 0", clk_fallo);
    else n_pass++;
    tick(0, 0, 16'h0000, 1);
    tick(0, 1, 16'hBEEF, 1);
    n_checks++;
    if (clk_fallo !== 1'b1 || bus.dout !== 16'hBEEF || bus.dout_valid !== 1'b1)
      $display("FAIL irregular: got %s want dout=beef v=1 fallo=1", fmt(dut_v));
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      tick(0, 1, 16'h0000, 1);
      n_checks++;
      if (dut_v !== mdl_v())
        $display("FAIL irregular_after c%0d: got %s want %s", c, fmt(dut_v), fmt(mdl_v()));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 1, 0, 0);
    for (int c = 0; c < 5; c++) tick(0, c >= 4, 16'h4242, 0);
    n_checks++;
    if (bus.dout_valid !== 1'b1) $display("FAIL reset_mid_pre: got v=%b want 1", bus.dout_valid);
    else n_pass++;
    tick(1, 1, 16'h9999, 0);
    n_checks++;
    if (dut_v !== '0) $display("FAIL reset_mid: got %s want all zero", fmt(dut_v));
    else n_pass++;
    for (int c = 0; c < 3; c++) tick(0, 1, 16'h7777, 0);
    n_checks++;
    if (bus.dout_valid !== 1'b0 || n_muestras !== CNT_W'(0))
      $display("FAIL reset_mid_no_spurious: got %s want v=0 n=0", fmt(dut_v));
    else n_pass++;
    for (int c = 0; c < 5; c++) tick(0, c >= 4, 16'h3C3C, 0);
    n_checks++;
    if (bus.dout !== 16'h3C3C || bus.dout_valid !== 1'b1 || n_muestras !== CNT_W'(1))
      $display("FAIL reset_mid_resume: got %s want dout=3c3c v=1 n=1", fmt(dut_v));
    else n_pass++;
  endtask

  task automatic test_random();
    int r, per, lo;
    tick(1, 1, 0, 0);
    for (int p = 0; p < 200; p++) begin
      r = $urandom_range(0, 99);
      if (r < 4) tick(1, $urandom_range(0, 1) == 1, 0, 0);
      per = (r < 10) ? $urandom_range(15, 22)
                     : $urandom_range(PERIODO - TOL - 2, PERIODO + TOL + 2);
      lo  = $urandom_range(1, per - 1);
      for (int c = 0; c < per; c++) begin
        tick(0, c >= lo, DATA_W'($urandom), $urandom_range(0, 3) != 0);
        n_checks++;
        if (dut_v !== mdl_v())
          $display("FAIL random p%0d c%0d: got %s want %s", p, c, fmt(dut_v), fmt(mdl_v()));
        else n_pass++;
      end
    end
  endtask

  initial begin
    bus.dout_ready = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_simultaneous();
    test_lost_clock();
    test_irregular();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
